// File: rtl/frame_streamer_if.sv
// frame_streamer_if: bundles the frame-buffer read port and the outgoing
// pixel stream of the frame streamer.
//   RAM read : rd_en, rd_addr ({y,x}) out of the streamer; rd_data back in
//              one cycle after rd_en.
//   Stream   : m_valid/m_ready handshake carrying m_data, m_sof, m_eol.
// master = streamer side, slave = RAM + display side.
interface frame_streamer_if #(
  parameter int DATA_W = 24,
  parameter int X_W    = 10,
  parameter int Y_W    = 10
);
  logic                 rd_en;
  logic [X_W+Y_W-1:0]   rd_addr;
  logic [DATA_W-1:0]    rd_data;
  logic                 m_valid;
  logic                 m_ready;
  logic [DATA_W-1:0]    m_data;
  logic                 m_sof;
  logic                 m_eol;

  modport master (
    output rd_en, rd_addr, m_valid, m_data, m_sof, m_eol,
    input  rd_data, m_ready
  );

  modport slave (
    input  rd_en, rd_addr, m_valid, m_data, m_sof, m_eol,
    output rd_data, m_ready
  );
endinterface

// File: rtl/frame_streamer.sv
// frame_streamer: read side of the Mandelbrot frame buffer. On start it
// reads every pixel of an x_size by y_size frame in raster order (x fastest)
// and emits it as a valid/ready stream tagged with start-of-frame and
// end-of-line markers.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   start         frame-ready pulse, only honoured in IDLE
//   x_size/y_size frame geometry, latched when start is accepted
//   bus           frame_streamer_if.master: RAM read port + pixel stream
//   busy          high from accepted start until the DONE cycle
//   done          one-cycle pulse after the last pixel handshake
module frame_streamer #(
  parameter int DATA_W = 24,
  parameter int X_W    = 10,
  parameter int Y_W    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [X_W-1:0]        x_size,
  input  logic [Y_W-1:0]        y_size,
  frame_streamer_if.master      bus,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  state_t state_q, state_d;

  logic [X_W-1:0] xs, x;
  logic [Y_W-1:0] ys, y;
  logic           last_x, last_y;

  // one read in flight: its markers ride alongside the RAM latency
  logic           p_vld, p_sof, p_eol;

  // 2-entry skid FIFO of {data, sof, eol}
  logic [DATA_W-1:0] mem_data [2];
  logic              mem_sof  [2];
  logic              mem_eol  [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              pop;
  logic [2:0]        occ;

  assign last_x = (x == xs - X_ONE);
  assign last_y = (y == ys - Y_ONE);

  assign bus.m_valid = (count != 2'd0);
  assign pop         = bus.m_valid & bus.m_ready;
  assign bus.m_data  = bus.m_valid ? mem_data[rd_ptr] : '0;
  assign bus.m_sof   = bus.m_valid & mem_sof[rd_ptr];
  assign bus.m_eol   = bus.m_valid & mem_eol[rd_ptr];

  // Slots already committed after this cycle's pop; issuing only below 2
  // guarantees every landing read has a free FIFO entry.
  assign occ        = {1'b0, count} + {2'b0, p_vld} - {2'b0, pop};
  assign bus.rd_en  = (state_q == STREAM) && (occ < 3'd2);
  assign bus.rd_addr = bus.rd_en ? {y, x} : '0;

  assign busy = (state_q == STREAM) || (state_q == DRAIN);
  assign done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = (x_size == '0 || y_size == '0) ? DONE : STREAM;
      STREAM: if (bus.rd_en && last_x && last_y) state_d = DRAIN;
      // finish on the handshake of the final buffered pixel
      DRAIN:  if (!p_vld && (count == 2'd0 || (count == 2'd1 && pop))) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xs <= '0; ys <= '0; x <= '0; y <= '0;
    end else if (state_q == IDLE && start) begin
      xs <= x_size; ys <= y_size; x <= '0; y <= '0;
    end else if (bus.rd_en) begin
      // on the final address x wraps but y holds; STREAM is left anyway
      if (last_x) begin
        x <= '0;
        if (!last_y) y <= y + Y_ONE;
      end else begin
        x <= x + X_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_vld <= 1'b0; p_sof <= 1'b0; p_eol <= 1'b0;
      wr_ptr <= 1'b0; rd_ptr <= 1'b0; count <= 2'd0;
    end else begin
      p_vld <= bus.rd_en;
      p_sof <= (x == '0) && (y == '0);
      p_eol <= last_x;
      if (p_vld) wr_ptr <= ~wr_ptr;
      if (pop)   rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, p_vld} - {1'b0, pop};
    end
  end

  // storage needs no reset: m_* are gated by m_valid
  always_ff @(posedge clk) begin
    if (p_vld) begin
      mem_data[wr_ptr] <= bus.rd_data;
      mem_sof[wr_ptr]  <= p_sof;
      mem_eol[wr_ptr]  <= p_eol;
    end
  end
endmodule

// File: tb/tb_frame_streamer.sv
module tb_frame_streamer;
  localparam int DATA_W = 24, X_W = 10, Y_W = 10;

  logic clk = 0, rst = 0, start = 0, busy, done;
  logic [X_W-1:0] x_size = '0;
  logic [Y_W-1:0] y_size = '0;

  frame_streamer_if #(.DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W)) bus();

  frame_streamer #(.DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W)) dut (
    .clk(clk), .rst(rst), .start(start), .x_size(x_size), .y_size(y_size),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
  } pix_t;

  pix_t exp_q[$];
  int checks = 0, errors = 0, cyc = 0, ready_mode = 0;
  logic [DATA_W-1:0] seed = '0;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM holding pixel value ({y,x} address) ^ seed, one-cycle read latency
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= DATA_W'(bus.rd_addr) ^ seed;

  // downstream ready: 0 = always, 1 = 1,0,0,1 pattern, 2 = random
  initial begin
    int ph;
    ph = 0;
    bus.m_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: bus.m_ready = 1;
        1: bus.m_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: bus.m_ready = ($urandom_range(0, 2) != 0);
      endcase
      ph++;
    end
  end

  // monitor / scoreboard
  int hs_cnt = 0, rd_cnt = 0, occ = 0, max_occ = 0, done_cnt = 0;
  int done_cyc = -1, last_hs_cyc = -1, first_vld_cyc = -1, first_rd_cyc = -1;
  bit prev_stall = 0;
  pix_t held, cur, e;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      prev_stall = 0; occ = 0;
    end else begin
      cur = {bus.m_data, bus.m_sof, bus.m_eol};
      if (prev_stall)
        chk(bus.m_valid && cur == held, "stall_hold", longint'(cur), longint'(held));
      if (bus.m_valid && bus.m_ready) begin
        hs_cnt++; last_hs_cyc = cyc;
        chk(exp_q.size() > 0, "unexpected_pixel", longint'(cur), 0);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk(cur == e, "pixel", longint'(cur), longint'(e));
        end
      end
      if (bus.m_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.rd_en && first_rd_cyc < 0) first_rd_cyc = cyc;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (bus.rd_en) rd_cnt++;
      occ = occ + int'(bus.rd_en) - int'(bus.m_valid && bus.m_ready);
      if (occ > max_occ) max_occ = occ;
      prev_stall = bus.m_valid && !bus.m_ready;
      held = cur;
    end
  end

  task automatic load_expect(input int xs, input int ys);
    pix_t p;
    for (int y = 0; y < ys; y++)
      for (int x = 0; x < xs; x++) begin
        p.data = DATA_W'(y * (1 << X_W) + x) ^ seed;
        p.sof  = (x == 0 && y == 0);
        p.eol  = (x == xs - 1);
        exp_q.push_back(p);
      end
  endtask

  // returns the cycle label following the start-sampling edge
  task automatic issue_start(input int xs, input int ys, output int st);
    done_cnt = 0; first_vld_cyc = -1; first_rd_cyc = -1;
    rd_cnt = 0; max_occ = 0; last_hs_cyc = -1; done_cyc = -1;
    @(posedge clk); #1;
    x_size = X_W'(xs); y_size = Y_W'(ys); start = 1;
    @(posedge clk); #1;
    start = 0; st = cyc;
    // new sizes must not affect the running frame
    x_size = X_W'($urandom); y_size = Y_W'($urandom);
  endtask

  task automatic run_frame(input int xs, input int ys, input int mode,
                           input logic [DATA_W-1:0] sd, input bit repulse);
    int st, bound, n;
    bit to;
    ready_mode = mode;
    seed = sd;
    n = xs * ys;
    load_expect(xs, ys);
    issue_start(xs, ys, st);
    bound = n * 4 + 20; to = 1;
    for (int i = 0; i < bound; i++) begin
      if (done_cnt > 0) begin to = 0; break; end
      start = repulse && (i == 4);
      @(posedge clk); #1;
    end
    start = 0;
    chk(!to, "done_timeout", done_cnt, 1);
    repeat (5) @(posedge clk);
    #1;
    chk(done_cnt == 1, "done_count", done_cnt, 1);
    chk(exp_q.size() == 0, "pixels_missing", exp_q.size(), 0);
    chk(rd_cnt == n, "read_count", rd_cnt, n);
    chk(max_occ <= 2, "occupancy", max_occ, 2);
    if (n > 0) begin
      // sampling edge N opens cycle N+1 (first rd_en); valid at N+3
      chk(first_rd_cyc == st, "first_rd_en", first_rd_cyc - st, 0);
      chk(first_vld_cyc == st + 2, "first_valid", first_vld_cyc - st, 2);
      chk(done_cyc == last_hs_cyc + 1, "done_latency", done_cyc - last_hs_cyc, 1);
      if (mode == 0)
        chk(last_hs_cyc - first_vld_cyc == n - 1, "no_bubbles", last_hs_cyc - first_vld_cyc, n - 1);
    end else begin
      chk(done_cyc >= st && done_cyc <= st + 1, "done_zero", done_cyc - st, 0);
      chk(first_vld_cyc < 0, "zero_no_valid", first_vld_cyc, -1);
    end
    exp_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk(!bus.m_valid && !bus.rd_en && !busy && !done, {tag, "_ctrl"},
        {bus.m_valid, bus.rd_en, busy, done}, 0);
    chk(bus.m_data == '0 && !bus.m_sof && !bus.m_eol && bus.rd_addr == '0, {tag, "_data"},
        longint'({bus.m_data, bus.m_sof, bus.m_eol}), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, base;
    bit to;
    #2;
    check_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1;

    run_frame(4, 3, 0, '0, 0);            // data = addr, full rate
    run_frame(4, 3, 1, '0, 0);            // 1,0,0,1 backpressure
    run_frame(0, 5, 0, DATA_W'($urandom), 0);
    run_frame(3, 0, 0, DATA_W'($urandom), 0);
    run_frame(1, 1, 2, '0, 0);

    // reset mid-frame after 5 pixels
    ready_mode = 0; seed = DATA_W'($urandom);
    load_expect(4, 3);
    issue_start(4, 3, st);
    base = hs_cnt; to = 1;
    for (int i = 0; i < 100; i++) begin
      if (hs_cnt >= base + 5) begin to = 0; break; end
      @(posedge clk); #1;
    end
    chk(!to, "mid_reset_wait", hs_cnt - base, 5);
    rst = 0;
    #1;
    check_idle_outputs("mid_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1;
    run_frame(2, 2, 2, DATA_W'($urandom), 0);

    run_frame(4, 3, 0, DATA_W'($urandom), 1);   // start re-pulsed while busy
    run_frame(1, 4, 2, DATA_W'($urandom), 0);   // every pixel is eol
    for (int k = 0; k < 4; k++)
      run_frame($urandom_range(1, 7), $urandom_range(1, 5), 2, DATA_W'($urandom), 0);
    run_frame(1023, 2, 0, DATA_W'($urandom), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Read side of the Mandelbrot frame buffer.
- Once the compute side has filled the RAM with one complete frame, the streamer reads every pixel in raster order and emits it as a valid/ready pixel stream toward the display path.
- Each pixel carries start-of-frame and end-of-line markers.
- Absorbs the RAM's 1-cycle read latency and downstream backpressure without dropping or duplicating pixels.

Parameters:
- DATA_W, 24, pixel width (RGB word from RAM).
- X_W, 10, width of x index and x_size.
- Y_W, 10, width of y index and y_size.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  frame-ready pulse from the compute side; sampled only in IDLE.
- x_size  in  X_W  pixels per line; latched at accepted start.
- y_size  in  Y_W  lines per frame; latched at accepted start.
- rd_en  out  1  RAM read enable.
- rd_addr  out  X_W+Y_W  RAM read address {y,x}, same packing as the write side.
- rd_data  in  DATA_W  RAM read data; valid the cycle after rd_en.
- m_valid  out  1  output pixel valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W  pixel value.
- m_sof  out  1  marks pixel (0,0).
- m_eol  out  1  marks pixel x = x_size-1.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset (rst=0, asynchronous)
  - All outputs 0; FSM to IDLE; buffer emptied; in-flight read discarded.
  - Applies equally mid-frame. The first start after rst rises begins a fresh frame.
- FSM states
  - IDLE: start=1 latches x_size/y_size and clears x,y to 0.
    - Either size 0 -> DONE.
    - Otherwise -> STREAM, busy=1.
    - start while not IDLE is ignored.
  - STREAM: issues reads in raster order, x fastest.
    - x wraps to 0 at x_size-1 and y increments.
    - After issuing address {y_size-1, x_size-1} -> DRAIN.
  - DRAIN: no new reads.
    - Waits until the in-flight read has landed, the buffer is empty and the last pixel has handshaken -> DONE.
  - DONE: done=1 for exactly one cycle; busy=0 -> IDLE.
- Read issue
  - In STREAM, rd_en=1 in any cycle where (buffer occupancy + in-flight - pop this cycle) < 2.
  - pop = m_valid & m_ready.
  - rd_addr is the current {y,x}. x,y advance only on cycles with rd_en=1.
  - rd_en=0 outside STREAM.
- Buffer
  - 2-entry FIFO of {data, sof, eol}; written the cycle rd_data is valid; head drives m_*.
  - sof and eol are computed at issue time and travel with the read through the pipeline.
  - m_valid = FIFO not empty.
  - While m_valid=1 and m_ready=0, m_data/m_sof/m_eol hold stable.
  - Simultaneous push and pop when full is not reachable, by the issue rule.
- Timing
  - start sampled at edge N: first rd_en in cycle N+1; first m_valid in cycle N+3.
  - With m_ready held 1, one pixel per cycle thereafter, with no bubbles.
  - done pulses the cycle after the last pixel handshake.
- Sizes
  - x_size = 1: every pixel has m_eol=1.
  - 1x1 frame: a single pixel with m_sof=m_eol=1.
  - Max size 1023x1023: addresses never exceed {1022,1022}.
  - x_size/y_size changes after start have no effect until the next frame.

Test Plan:
- 4x3 frame, m_ready=1 constantly, RAM preloaded with data = addr -> 12 pixels in one burst.
  - Addresses in order 0x00000..0x00003, 0x00400..0x00403, 0x00800..0x00803.
  - m_sof only on the first pixel; m_eol on pixels 4, 8 and 12.
  - done exactly 1 cycle after the 12th handshake; first m_valid at N+3.
- Same frame, m_ready driven 1,0,0,1 repeating -> all 12 pixels appear exactly once, in order.
  - m_data stable during stalls; rd_en never raises occupancy above 2.
- x_size=0, y_size=5 -> rd_en never asserted; done pulses within 2 cycles of start; no m_valid.
- 1x1 frame -> single pixel at address 0 with m_sof=m_eol=1, then done.
- rst asserted mid-frame after 5 pixels, then released and start re-issued with 2x2 -> outputs go 0 immediately.
  - New frame begins at address 0; no stale buffered pixel is emitted.
- start pulsed again while busy on a 4x3 frame -> ignored; exactly 12 pixels emitted and one done pulse.
